uart_tx_8n1: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 41 ++++
 rtl/uart_tx_8n1.sv | 120 ++++++++++++
 tb/tb_uart_tx_8n1.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and frame constants for the 8N1 UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period counter; flags the last cycle of each bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Wrap at the bit boundary so consecutive bits never accumulate drift.
    always_comb begin
        w_count_d = r_count_q + CNT_W'(1);
        if (clear || (r_count_q == C_LAST)) begin
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign bit_end = (r_count_q == C_LAST);

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_8n1
// Description : 8N1 UART transmitter; sends back-to-back frames while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] tx_buf,
    output logic       serial_out,
    output logic       done
);

    localparam logic [BIT_IDX_W-1:0] C_LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    state_e                 r_state_q;
    state_e                 w_state_d;
    logic [DATA_BITS-1:0]   r_data_q;
    logic [DATA_BITS-1:0]   w_data_d;
    logic [BIT_IDX_W-1:0]   r_bit_idx_q;
    logic [BIT_IDX_W-1:0]   w_bit_idx_d;
    logic                   r_serial_q;
    logic                   w_serial_d;
    logic                   r_done_q;
    logic                   w_done_d;
    logic                   w_bit_end;
    logic                   w_baud_clear;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_baud_clear),
        .bit_end (w_bit_end)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_data_d    = r_data_q;
        w_bit_idx_d = r_bit_idx_q;

        case (r_state_q)
            IDLE: begin
                if (enable) begin
                    w_state_d   = START;
                    w_data_d    = tx_buf;
                    w_bit_idx_d = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_d   = DATA;
                    w_bit_idx_d = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx_q == C_LAST_BIT) begin
                        w_state_d = STOP;
                    end else begin
                        w_bit_idx_d = r_bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Each state starts with a full bit period.
        w_baud_clear = (w_state_d != r_state_q);

        // Outputs decode the next state so the registered line changes on the
        // same edge that changes state.
        w_serial_d = 1'b1;
        w_done_d   = 1'b0;
        case (w_state_d)
            START:   w_serial_d = 1'b0;
            DATA:    w_serial_d = w_data_d[w_bit_idx_d];
            DONE:    w_done_d   = 1'b1;
            default: w_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q   <= IDLE;
            r_data_q    <= '0;
            r_bit_idx_q <= '0;
            r_serial_q  <= 1'b1;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_data_q    <= w_data_d;
            r_bit_idx_q <= w_bit_idx_d;
            r_serial_q  <= w_serial_d;
            r_done_q    <= w_done_d;
        end
    end

    assign serial_out = r_serial_q;
    assign done       = r_done_q;

endmodule : uart_tx_8n1
`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_8n1
// Description : Directed self-checking bench for uart_tx_8n1 at 4 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_8n1;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] tx_buf;
    logic       serial_out;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [40:0] c_dn_exp = {1'b1, 40'b0};

    uart_tx_8n1 #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tx_buf     (tx_buf),
        .serial_out (serial_out),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for each of the 40 cycles of a frame.
    function automatic logic [39:0] frame_exp(input logic [7:0] b);
        logic [39:0] v;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       v[i] = 1'b0;
            else if (i < 36) v[i] = b[(i - 4) / 4];
            else             v[i] = 1'b1;
        end
        return v;
    endfunction

    // Waits (bounded) for the start bit, then records 40 line samples and
    // 41 done samples. act 1 rewrites tx_buf, act 2 drops enable at act_idx.
    task automatic capture_frame(input int act_idx, input int act,
                                 output int wait_cyc, output logic [39:0] line,
                                 output logic [40:0] dn, output logic [7:0] rx);
        bit found;
        found    = 1'b0;
        wait_cyc = 0;
        line     = '1;
        dn       = '0;
        rx       = '0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            wait_cyc++;
            if (serial_out === 1'b0) found = 1'b1;
        end
        if (!found) begin
            wait_cyc = -1;
            return;
        end
        for (int i = 0; i < 41; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 40) line[i] = serial_out;
            dn[i] = done;
            if (i == act_idx) begin
                if (act == 1) tx_buf = 8'hFF;
                if (act == 2) enable = 1'b0;
            end
        end
        for (int k = 0; k < 8; k++) rx[k] = line[4 * k + 5];
    endtask

    task automatic test_reset();
        int w; logic [39:0] ln; logic [40:0] dn; logic [7:0] rx;
        reset  = 1'b1;
        enable = 1'b1;
        tx_buf = 8'h13;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (serial_out !== 1'b1) $display("FAIL reset_serial_async: got %b want 1", serial_out);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done_async: got %b want 0", done);
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({serial_out, done} !== 2'b10)
                $display("FAIL reset_hold_cycle%0d: got serial=%b done=%b want serial=1 done=0", c, serial_out, done);
            else pass_cnt++;
        end
        reset = 1'b1;
        capture_frame(-1, 0, w, ln, dn, rx);
        enable = 1'b0;
        total_cnt++;
        if (w !== 1) $display("FAIL reset_first_start: got wait %0d want 1", w);
        else pass_cnt++;
        total_cnt++;
        if (rx !== 8'h13) $display("FAIL reset_first_byte: got %h want 13", rx);
        else pass_cnt++;
    endtask

    task automatic test_single_byte();
        int w; logic [39:0] ln; logic [40:0] dn; logic [7:0] rx; bit idle_ok;
        repeat (3) @(negedge clk);
        tx_buf = 8'h13;
        enable = 1'b1;
        capture_frame(-1, 0, w, ln, dn, rx);
        enable = 1'b0;
        total_cnt++;
        if (w !== 1) $display("FAIL single_latency: got wait %0d want 1", w);
        else pass_cnt++;
        total_cnt++;
        if (ln !== frame_exp(8'h13)) $display("FAIL single_line: got %b want %b", ln, frame_exp(8'h13));
        else pass_cnt++;
        total_cnt++;
        if (dn !== c_dn_exp) $display("FAIL single_done_timing: got %b want %b", dn, c_dn_exp);
        else pass_cnt++;
        total_cnt++;
        if (rx !== 8'h13) $display("FAIL single_byte: got %h want 13", rx);
        else pass_cnt++;
        idle_ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if ({serial_out, done} !== 2'b10) idle_ok = 1'b0;
        end
        total_cnt++;
        if (!idle_ok) $display("FAIL single_idle_after: got line/done activity want idle high, no done");
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3; logic [39:0] ln; logic [40:0] dn; logic [7:0] r1, r2, r3;
        repeat (3) @(negedge clk);
        tx_buf = 8'h13;
        enable = 1'b1;
        capture_frame(-1, 0, w1, ln, dn, r1);
        tx_buf = 8'h37;
        capture_frame(-1, 0, w2, ln, dn, r2);
        tx_buf = 8'h00;
        capture_frame(-1, 0, w3, ln, dn, r3);
        enable = 1'b0;
        total_cnt++;
        if (r1 !== 8'h13) $display("FAIL b2b_byte1: got %h want 13", r1);
        else pass_cnt++;
        total_cnt++;
        if (r2 !== 8'h37) $display("FAIL b2b_byte2: got %h want 37", r2);
        else pass_cnt++;
        total_cnt++;
        if (r3 !== 8'h00) $display("FAIL b2b_byte3: got %h want 00", r3);
        else pass_cnt++;
        total_cnt++;
        if (40 + w2 !== 42) $display("FAIL b2b_period12: got %0d want 42", 40 + w2);
        else pass_cnt++;
        total_cnt++;
        if (40 + w3 !== 42) $display("FAIL b2b_period23: got %0d want 42", 40 + w3);
        else pass_cnt++;
        total_cnt++;
        if (ln !== frame_exp(8'h00)) $display("FAIL b2b_line3: got %b want %b", ln, frame_exp(8'h00));
        else pass_cnt++;
        total_cnt++;
        if (dn !== c_dn_exp) $display("FAIL b2b_done3: got %b want %b", dn, c_dn_exp);
        else pass_cnt++;
    endtask

    task automatic test_txbuf_change();
        int w; logic [39:0] ln; logic [40:0] dn; logic [7:0] rx;
        repeat (3) @(negedge clk);
        tx_buf = 8'h13;
        enable = 1'b1;
        capture_frame(10, 1, w, ln, dn, rx);
        enable = 1'b0;
        total_cnt++;
        if (rx !== 8'h13) $display("FAIL txbuf_change_byte: got %h want 13", rx);
        else pass_cnt++;
        total_cnt++;
        if (ln !== frame_exp(8'h13)) $display("FAIL txbuf_change_line: got %b want %b", ln, frame_exp(8'h13));
        else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        int w; logic [39:0] ln; logic [40:0] dn; logic [7:0] rx; bit idle_ok;
        repeat (3) @(negedge clk);
        tx_buf = 8'hB6;
        enable = 1'b1;
        capture_frame(17, 2, w, ln, dn, rx);
        total_cnt++;
        if (rx !== 8'hB6) $display("FAIL en_drop_byte: got %h want b6", rx);
        else pass_cnt++;
        total_cnt++;
        if (dn !== c_dn_exp) $display("FAIL en_drop_done: got %b want %b", dn, c_dn_exp);
        else pass_cnt++;
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if ({serial_out, done} !== 2'b10) idle_ok = 1'b0;
        end
        total_cnt++;
        if (!idle_ok) $display("FAIL en_drop_no_restart: got activity after frame want idle high");
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int w; logic [39:0] ln; logic [40:0] dn; logic [7:0] rx; bit found; bit held_ok;
        repeat (3) @(negedge clk);
        tx_buf = 8'hA5;
        enable = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (serial_out === 1'b0) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL arst_frame_start: got no start bit want start within 10 cycles");
        else pass_cnt++;
        // Sample 10 falls in data bit 1, which is 0 for 0xA5.
        repeat (10) @(negedge clk);
        tx_buf = 8'hC3;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (serial_out !== 1'b1) $display("FAIL arst_serial_immediate: got %b want 1", serial_out);
        else pass_cnt++;
        held_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({serial_out, done} !== 2'b10) held_ok = 1'b0;
        end
        total_cnt++;
        if (!held_ok) $display("FAIL arst_hold: got activity in reset want serial=1 done=0");
        else pass_cnt++;
        reset = 1'b1;
        capture_frame(-1, 0, w, ln, dn, rx);
        enable = 1'b0;
        total_cnt++;
        if (w !== 1) $display("FAIL arst_restart_latency: got wait %0d want 1", w);
        else pass_cnt++;
        total_cnt++;
        if (ln !== frame_exp(8'hC3)) $display("FAIL arst_fresh_line: got %b want %b", ln, frame_exp(8'hC3));
        else pass_cnt++;
        total_cnt++;
        if (dn !== c_dn_exp) $display("FAIL arst_fresh_done: got %b want %b", dn, c_dn_exp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_txbuf_change();
        test_enable_drop();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_uart_tx_8n1
`default_nettype wire
